sram_bank_arb: RTL and testbench
================================

SRAM_BANK_ARB -- requirements
Module: sram_bank_arb

Interface
REQ-001 Parameter NUM_BANKS, default 2, number of 32x512 SRAM macros served (legal 1..8).
REQ-002 Parameter BANK_AW, default 9, word-address width per macro.
REQ-003 Localparam AW = BANK_AW + max(1, clog2(NUM_BANKS)), width of the word address seen by the requesters.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 wb_clk_i  in  1  sole clock; all flops on its rising edge.
REQ-006 wb_rstn_i  in  1  synchronous active-low reset.
REQ-007 pN_req_i, N in {0,1}  in  1  port N request (P0 core, P1 wishbone loader).
REQ-008 pN_gnt_o  out  1  request accepted this cycle.
REQ-009 pN_we_i  in  1  1 = write.
REQ-010 pN_be_i  in  4  byte enables.
REQ-011 pN_addr_i  in  AW  word address; bank = addr[AW-1:BANK_AW].
REQ-012 pN_wdata_i  in  32  write data.
REQ-013 pN_rvalid_o  out  1  response valid (read data or write ack).
REQ-014 pN_rdata_o  out  32  read data.
REQ-015 pN_err_o  out  1  qualifies rvalid: address decoded to a non-existent bank.
REQ-016 sram_clk0_o  out  1  equal to wb_clk_i.
REQ-017 sram_csb0_o  out  NUM_BANKS  active-low chip selects, one per bank.
REQ-018 sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o  out  1/4/BANK_AW/32  shared macro controls.
REQ-019 sram_dout0_i  in  32*NUM_BANKS  macro read data, bank b at bits [32b+31:32b].

Function
REQ-020 At most one port SHALL be granted per cycle; gnt is combinational from req and arbitration state.
REQ-021 A lone requester SHALL be granted in the same cycle.
REQ-022 Granted port drives sram_* controls; csb0[b]=0 only for the decoded bank b, all other csb bits 1.
REQ-023 sram_web0_o = ~we of granted port; wmask0 = be; din0 = wdata; addr0 = addr[BANK_AW-1:0].
REQ-024 With no grant, all csb bits SHALL be 1 and web0 SHALL be 1.
REQ-025 Grant in cycle T SHALL produce exactly one rvalid pulse on the same port in cycle T+1; back-to-back grants give back-to-back responses.
REQ-026 Read response: rdata = sram_dout0_i slice of the bank registered at grant; write response: rdata = 0.
REQ-027 Bank index >= NUM_BANKS: grant still given, no csb asserted, response at T+1 with err=1 and rdata=32'hDEAD_BEEF.
REQ-028 rdata SHALL be 0 and err SHALL be 0 whenever rvalid is 0.
REQ-029 Ungranted port SHALL hold its request; block stores no pending requests (no queue).

Reset
REQ-030 While wb_rstn_i=0 at a clock edge: rvalid, err, registered bank/port state cleared; RR pointer set to favour P0.
REQ-031 While wb_rstn_i=0, both gnt SHALL be 0 and all csb bits 1, regardless of requests.
REQ-032 Reset asserted in the cycle after a grant SHALL suppress that response (no rvalid at T+1).

Configuration
REQ-033 Macro SRAM_BANK_ARB_RR_EN defined: round-robin — on conflict, port not granted most recently wins; pointer updates only on a grant.
REQ-034 Macro SRAM_BANK_ARB_RR_EN undefined: fixed priority, P1 (loader) always wins conflicts; no pointer flop exists.

Verification
REQ-035 P0 write addr 0x205, be=4'hF, data 32'h1234_5678, NUM_BANKS=2 -> same cycle gnt, csb0=2'b01, addr0=0x005, web0=0; next cycle p0_rvalid=1, rdata=0.
REQ-036 P0 read addr 0x005, bank 0 dout=32'hCAFE_F00D held -> p0_rvalid at T+1, rdata=32'hCAFE_F00D, err=0.
REQ-037 NUM_BANKS=3, P1 read addr 0x600 -> gnt=1, csb=3'b111; T+1 p1_rvalid=1, err=1, rdata=32'hDEAD_BEEF.
REQ-038 Both ports request 4 cycles continuously: RR_EN -> grants P0,P1,P0,P1; no macro -> P1 x4, P0 never.
REQ-039 Grant at T, wb_rstn_i=0 at T+1 -> no rvalid at T+1, gnt=0 and csb all 1 while reset low.
REQ-040 P0 reads on 8 consecutive cycles alternating banks 0/1 -> 8 consecutive rvalid pulses, each with the correct bank's data.

Source files
------------

// File: rtl/sram_bank_arb.sv
// Two-port arbiter in front of NUM_BANKS single-port SRAM macros; one access per cycle, response one cycle later.
// Define SRAM_BANK_ARB_RR_EN for round-robin arbitration; otherwise P1 (loader) has fixed priority.
module sram_bank_arb #(
    parameter  int NUM_BANKS = 2,
    parameter  int BANK_AW   = 9,
    localparam int BSW       = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int AW        = BANK_AW + BSW
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rstn_i,

    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic                    p0_we_i,
    input  logic [3:0]              p0_be_i,
    input  logic [AW-1:0]           p0_addr_i,
    input  logic [31:0]             p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [31:0]             p0_rdata_o,
    output logic                    p0_err_o,

    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic                    p1_we_i,
    input  logic [3:0]              p1_be_i,
    input  logic [AW-1:0]           p1_addr_i,
    input  logic [31:0]             p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [31:0]             p1_rdata_o,
    output logic                    p1_err_o,

    output logic                    sram_clk0_o,
    output logic [NUM_BANKS-1:0]    sram_csb0_o,
    output logic                    sram_web0_o,
    output logic [3:0]              sram_wmask0_o,
    output logic [BANK_AW-1:0]      sram_addr0_o,
    output logic [31:0]             sram_din0_o,
    input  logic [32*NUM_BANKS-1:0] sram_dout0_i
);

    logic           gnt0, gnt1, gnt_any;
    logic           sel_we;
    logic [3:0]     sel_be;
    logic [AW-1:0]  sel_addr;
    logic [31:0]    sel_wdata;
    logic [BSW-1:0] sel_bank;
    logic           sel_ok;

    logic [1:0]     rvalid_q, rvalid_d;
    logic           err_q, err_d;
    logic           we_q, we_d;
    logic [BSW-1:0] bank_q, bank_d;
    logic [31:0]    rd_word;
    logic [31:0]    resp_data;

`ifdef SRAM_BANK_ARB_RR_EN
    // last_q = 1 means P1 was granted most recently, so P0 wins the next conflict.
    logic           last_q, last_d;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (wb_rstn_i) begin
            if (p0_req_i && p1_req_i) begin
`ifdef SRAM_BANK_ARB_RR_EN
                gnt0 = last_q;
                gnt1 = ~last_q;
`else
                gnt1 = 1'b1;
`endif
            end else begin
                gnt0 = p0_req_i;
                gnt1 = p1_req_i;
            end
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign p0_gnt_o  = gnt0;
    assign p1_gnt_o  = gnt1;

    assign sel_we    = gnt1 ? p1_we_i    : p0_we_i;
    assign sel_be    = gnt1 ? p1_be_i    : p0_be_i;
    assign sel_addr  = gnt1 ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = gnt1 ? p1_wdata_i : p0_wdata_i;
    assign sel_bank  = sel_addr[AW-1:BANK_AW];
    assign sel_ok    = int'(sel_bank) < NUM_BANKS;

    always_comb begin
        sram_csb0_o = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt_any && sel_ok && (int'(sel_bank) == b)) begin
                sram_csb0_o[b] = 1'b0;
            end
        end
    end

    assign sram_clk0_o   = wb_clk_i;
    assign sram_web0_o   = gnt_any ? ~sel_we : 1'b1;
    assign sram_wmask0_o = sel_be;
    assign sram_addr0_o  = sel_addr[BANK_AW-1:0];
    assign sram_din0_o   = sel_wdata;

    always_comb begin
        rvalid_d = {gnt1, gnt0};
        err_d    = gnt_any & ~sel_ok;
        we_d     = sel_we;
        bank_d   = sel_bank;
`ifdef SRAM_BANK_ARB_RR_EN
        last_d   = gnt_any ? gnt1 : last_q;
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            rvalid_q <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            bank_q   <= '0;
`ifdef SRAM_BANK_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            we_q     <= we_d;
            bank_q   <= bank_d;
`ifdef SRAM_BANK_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    // Macro output is valid the cycle after the access, so select it with the registered bank.
    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(bank_q) == b) begin
                rd_word = sram_dout0_i[32*b +: 32];
            end
        end
    end

    assign resp_data = err_q ? 32'hDEAD_BEEF : (we_q ? 32'h0 : rd_word);

    // Gating with reset drops a response whose cycle is already under reset.
    assign p0_rvalid_o = rvalid_q[0] & wb_rstn_i;
    assign p1_rvalid_o = rvalid_q[1] & wb_rstn_i;
    assign p0_err_o    = p0_rvalid_o & err_q;
    assign p1_err_o    = p1_rvalid_o & err_q;
    assign p0_rdata_o  = p0_rvalid_o ? resp_data : 32'h0;
    assign p1_rdata_o  = p1_rvalid_o ? resp_data : 32'h0;

endmodule

// File: tb/tb_sram_bank_arb.sv
// Directed bench for sram_bank_arb: a 2-bank and a 3-bank instance share the same stimulus.
module tb_sram_bank_arb;

`ifdef SRAM_BANK_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [3:0]  p0_be, p1_be;
    logic [10:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [95:0] dout;

    logic        p0_gnt2, p1_gnt2, p0_rv2, p1_rv2, p0_err2, p1_err2, clk2, web2;
    logic [31:0] p0_rd2, p1_rd2, din2;
    logic [1:0]  csb2;
    logic [3:0]  wm2;
    logic [8:0]  a2;

    logic        p0_gnt3, p1_gnt3, p0_rv3, p1_rv3, p0_err3, p1_err3, clk3, web3;
    logic [31:0] p0_rd3, p1_rd3, din3;
    logic [2:0]  csb3;
    logic [3:0]  wm3;
    logic [8:0]  a3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bank_arb #(.NUM_BANKS(2), .BANK_AW(9)) u_dut2 (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt2), .p0_we_i(p0_we), .p0_be_i(p0_be),
        .p0_addr_i(p0_addr[9:0]), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rv2),
        .p0_rdata_o(p0_rd2), .p0_err_o(p0_err2),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt2), .p1_we_i(p1_we), .p1_be_i(p1_be),
        .p1_addr_i(p1_addr[9:0]), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rv2),
        .p1_rdata_o(p1_rd2), .p1_err_o(p1_err2),
        .sram_clk0_o(clk2), .sram_csb0_o(csb2), .sram_web0_o(web2), .sram_wmask0_o(wm2),
        .sram_addr0_o(a2), .sram_din0_o(din2), .sram_dout0_i(dout[63:0])
    );

    sram_bank_arb #(.NUM_BANKS(3), .BANK_AW(9)) u_dut3 (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt3), .p0_we_i(p0_we), .p0_be_i(p0_be),
        .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rv3),
        .p0_rdata_o(p0_rd3), .p0_err_o(p0_err3),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt3), .p1_we_i(p1_we), .p1_be_i(p1_be),
        .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rv3),
        .p1_rdata_o(p1_rd3), .p1_err_o(p1_err3),
        .sram_clk0_o(clk3), .sram_csb0_o(csb3), .sram_web0_o(web3), .sram_wmask0_o(wm3),
        .sram_addr0_o(a3), .sram_din0_o(din3), .sram_dout0_i(dout)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [3:0] be,
                          input logic [10:0] addr, input logic [31:0] wd);
        p0_req = req; p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [3:0] be,
                          input logic [10:0] addr, input logic [31:0] wd);
        p1_req = req; p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wd;
    endtask

    initial begin
        logic [31:0] bank_data [3];
        logic        e0 [4];
        logic        e1 [4];
        logic [31:0] prev_data;

        bank_data[0] = 32'hCAFE_F00D;
        bank_data[1] = 32'h1111_2222;
        bank_data[2] = 32'h3333_4444;
        dout = {bank_data[2], bank_data[1], bank_data[0]};

        // reset with both ports requesting
        rstn = 1'b0;
        set_p0(1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
        set_p1(1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
        tick(); tick();
        check_eq("rst_gnt0", 32'(p0_gnt2), 0);
        check_eq("rst_gnt1", 32'(p1_gnt2), 0);
        check_eq("rst_csb2", 32'(csb2), 32'h3);
        check_eq("rst_csb3", 32'(csb3), 32'h7);
        check_eq("rst_web", 32'(web2), 1);
        check_eq("rst_rvalid", 32'({p0_rv2, p1_rv2}), 0);
        check_eq("rst_rdata", p0_rd2 | p1_rd2, 0);

        set_p0(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        set_p1(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        tick();
        rstn = 1'b1;
        #1;
        check_eq("idle_csb", 32'(csb2), 32'h3);
        check_eq("idle_web", 32'(web2), 1);
        tick();

        // P0 write 0x205
        set_p0(1'b1, 1'b1, 4'hF, 11'h205, 32'h1234_5678);
        #1;
        check_eq("wr_gnt0", 32'(p0_gnt2), 1);
        check_eq("wr_gnt1", 32'(p1_gnt2), 0);
        check_eq("wr_csb2", 32'(csb2), 32'h1);
        check_eq("wr_csb3", 32'(csb3), 32'h5);
        check_eq("wr_addr0", 32'(a2), 32'h005);
        check_eq("wr_web", 32'(web2), 0);
        check_eq("wr_wmask", 32'(wm2), 32'hF);
        check_eq("wr_din", din2, 32'h1234_5678);
        tick();
        set_p0(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        #1;
        check_eq("wr_rvalid", 32'(p0_rv2), 1);
        check_eq("wr_rdata", p0_rd2, 0);
        check_eq("wr_err", 32'(p0_err2), 0);
        check_eq("wr_p1_rvalid", 32'(p1_rv2), 0);
        tick();
        check_eq("wr_single_pulse", 32'(p0_rv2), 0);

        // P0 read 0x005 from bank 0
        set_p0(1'b1, 1'b0, 4'hF, 11'h005, 32'h0);
        #1;
        check_eq("rd_gnt0", 32'(p0_gnt2), 1);
        check_eq("rd_csb2", 32'(csb2), 32'h2);
        check_eq("rd_web", 32'(web2), 1);
        tick();
        set_p0(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        #1;
        check_eq("rd_rvalid", 32'(p0_rv2), 1);
        check_eq("rd_rdata", p0_rd2, 32'hCAFE_F00D);
        check_eq("rd_err", 32'(p0_err2), 0);
        tick();

        // P1 read 0x600: bank 3 absent on the 3-bank instance
        set_p1(1'b1, 1'b0, 4'hF, 11'h600, 32'h0);
        #1;
        check_eq("oob_gnt1", 32'(p1_gnt3), 1);
        check_eq("oob_csb3", 32'(csb3), 32'h7);
        check_eq("oob_web3", 32'(web3), 1);
        tick();
        set_p1(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        #1;
        check_eq("oob_rvalid", 32'(p1_rv3), 1);
        check_eq("oob_err", 32'(p1_err3), 1);
        check_eq("oob_rdata", p1_rd3, 32'hDEAD_BEEF);
        check_eq("b1_rdata2", p1_rd2, 32'h1111_2222);
        check_eq("b1_err2", 32'(p1_err2), 0);
        tick();
        check_eq("oob_err_clear", 32'(p1_err3), 0);

        // P1 write 0x1FF with partial byte enables
        set_p1(1'b1, 1'b1, 4'h5, 11'h1FF, 32'hAABB_CCDD);
        #1;
        check_eq("p1wr_csb2", 32'(csb2), 32'h2);
        check_eq("p1wr_addr0", 32'(a2), 32'h1FF);
        check_eq("p1wr_wmask", 32'(wm2), 32'h5);
        check_eq("p1wr_din", din2, 32'hAABB_CCDD);
        check_eq("p1wr_web", 32'(web2), 0);
        tick();
        set_p1(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        #1;
        check_eq("p1wr_rvalid", 32'(p1_rv2), 1);
        check_eq("p1wr_rdata", p1_rd2, 0);
        tick();

        // 4-cycle conflict; P1 was granted last
        for (int i = 0; i < 4; i++) begin
            e0[i] = RR ? ((i % 2) == 0) : 1'b0;
            e1[i] = RR ? ((i % 2) == 1) : 1'b1;
        end
        set_p0(1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
        set_p1(1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("conf_gnt0_%0d", i), 32'(p0_gnt2), 32'(e0[i]));
            check_eq($sformatf("conf_gnt1_%0d", i), 32'(p1_gnt2), 32'(e1[i]));
            if (i > 0) begin
                check_eq($sformatf("conf_rv0_%0d", i), 32'(p0_rv2), 32'(e0[i-1]));
                check_eq($sformatf("conf_rv1_%0d", i), 32'(p1_rv2), 32'(e1[i-1]));
            end
            tick();
        end
        set_p0(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        set_p1(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        #1;
        check_eq("conf_rv0_4", 32'(p0_rv2), 32'(e0[3]));
        check_eq("conf_rv1_4", 32'(p1_rv2), 32'(e1[3]));
        tick();

        // reset in the cycle after a grant
        set_p0(1'b1, 1'b0, 4'hF, 11'h005, 32'h0);
        #1;
        check_eq("rstg_gnt0", 32'(p0_gnt2), 1);
        tick();
        rstn = 1'b0;
        #1;
        check_eq("rstg_rvalid", 32'(p0_rv2), 0);
        check_eq("rstg_rdata", p0_rd2, 0);
        check_eq("rstg_gnt0_low", 32'(p0_gnt2), 0);
        check_eq("rstg_csb", 32'(csb2), 32'h3);
        tick();
        set_p1(1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
        #1;
        check_eq("rstg_rvalid2", 32'(p0_rv2), 0);
        check_eq("rstg_gnt_both", 32'({p0_gnt2, p1_gnt2}), 0);
        tick();
        rstn = 1'b1;
        #1;
        check_eq("post_rst_gnt0", 32'(p0_gnt2), 32'(RR));
        check_eq("post_rst_gnt1", 32'(p1_gnt2), 32'(!RR));
        set_p0(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        set_p1(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        tick();
        tick();

        // 8 back-to-back P0 reads alternating banks
        prev_data = 32'h0;
        for (int i = 0; i < 8; i++) begin
            set_p0(1'b1, 1'b0, 4'hF, ((i % 2) == 1) ? (11'h200 | 11'(i)) : 11'(i), 32'h0);
            #1;
            check_eq($sformatf("alt_gnt_%0d", i), 32'(p0_gnt2), 1);
            check_eq($sformatf("alt_csb_%0d", i), 32'(csb2), ((i % 2) == 1) ? 32'h1 : 32'h2);
            if (i > 0) begin
                check_eq($sformatf("alt_rv_%0d", i), 32'(p0_rv2), 1);
                check_eq($sformatf("alt_rd_%0d", i), p0_rd2, prev_data);
            end
            prev_data = bank_data[i % 2];
            tick();
        end
        set_p0(1'b0, 1'b0, 4'h0, 11'h000, 32'h0);
        #1;
        check_eq("alt_rv_8", 32'(p0_rv2), 1);
        check_eq("alt_rd_8", p0_rd2, 32'h1111_2222);
        tick();
        check_eq("alt_end_rv", 32'(p0_rv2), 0);
        check_eq("alt_end_rd", p0_rd2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
